median_window_gen: RTL and testbench
====================================

Name: median_window_gen

Overview:
Upstream feeder for bubble_sort_unit in the median filter datapath. Accepts a raster-order pixel stream and keeps two line buffers plus a 3x3 window register. For every interior pixel it presents the nine window pixels to the sort unit and pulses start. It stalls the input stream until the sort unit reports completion.

Parameters:
BITWIDTH, 8, pixel width (matches `BITWIDTH of the sort unit)
IMG_WIDTH, 640, pixels per row (min 3)
IMG_HEIGHT, 480, rows per frame (min 3)
COL_W, 10, column counter width (2^COL_W >= IMG_WIDTH)
ROW_W, 9, row counter width (2^ROW_W >= IMG_HEIGHT)

Ports:
CLK  input  1  clock, single domain, rising edge
RST  input  1  asynchronous active-low reset (0 = reset, 1 = run)
pix_valid_i  input  1  input pixel valid
pix_data_i  input  BITWIDTH  input pixel, raster order
pix_ready_o  output  1  block can accept a pixel this cycle
win0_o..win8_o  output  BITWIDTH each  3x3 window, row-major: win0 top-left, win8 bottom-right (newest pixel)
start_o  output  1  one-cycle start pulse to the sort unit
sort_valid_i  input  1  valid_o from the sort unit
center_row_o  output  ROW_W  row of the window centre
center_col_o  output  COL_W  column of the window centre
frame_done_o  output  1  one-cycle pulse after the last pixel of a frame is accepted

Behaviour:
- Reset values (async, RST=0): state IDLE, col/row counters 0, win0..win8 = 0, start_o = 0, frame_done_o = 0, center_* = 0, sort_valid_i edge register = 0. pix_ready_o = 0 while RST = 0. Line buffer contents are not cleared.
- Accept: occurs when pix_valid_i and pix_ready_o are both high. pix_ready_o = 1 only in IDLE.
- On accept at column c:
  - Read lb1[c] and lb0[c] (old values, combinational read).
  - Write lb1[c] <= lb0[c] and lb0[c] <= pix_data_i.
  - Shift window columns left by one. The new right column is (top, mid, bottom) = (lb1[c], lb0[c], pix_data_i).
- Counters:
  - col increments on each accept. At IMG_WIDTH-1 it wraps to 0 and row increments.
  - At row IMG_HEIGHT-1 and col IMG_WIDTH-1, both wrap to 0 and frame_done_o pulses in the next cycle.
- Window-complete condition: an accept with row >= 2 and col >= 2, using the pre-increment counters. No border padding, so each frame yields (IMG_WIDTH-2)*(IMG_HEIGHT-2) windows.
- FSM:
  - IDLE -> START on a window-complete accept. center_row_o = row-1 and center_col_o = col-1 are registered with the window.
  - Any other accept leaves the FSM in IDLE.
  - START: start_o = 1 for exactly one cycle, then go to WAIT.
  - WAIT: leave on a rising edge of sort_valid_i (sort_valid_i = 1 and its registered copy = 0), then go to IDLE. A level that stays high from a previous sort is ignored.
- Stability: win0..win8 and center_* stay constant from START until return to IDLE. They change only on accept.
- Latency: start_o asserts 1 cycle after the completing accept. pix_ready_o returns 1 the cycle after the sort_valid_i rising edge.
- Throughput: one pixel per cycle on non-window pixels. Window pixels cost 2 + sort latency cycles.
- Reset mid-operation (START or WAIT): return to IDLE immediately, drop start_o, zero the counters. The next frame starts at (0,0). Stale line-buffer data is never emitted, because row gating is >= 2.
- pix_valid_i held high while ready = 0: pixel is neither consumed nor lost; it is accepted on the first ready cycle.

Test Plan:
1. Reset: assert RST=0 mid-idle -> all outputs 0 and pix_ready_o = 0. After RST=1, pix_ready_o = 1 next cycle.
2. IMG_WIDTH=4, IMG_HEIGHT=4, pixel = row*4+col+1, sort model raises valid 3 cycles after start -> exactly 4 windows.
   - First window after pixel 11: win0..8 = 1,2,3,5,6,7,9,10,11, centre (1,1).
   - Remaining centres: (1,2), (2,1), (2,2).
3. Same stream with pix_valid_i held high continuously -> pix_ready_o low from the START cycle through the valid edge. No pixel is dropped or duplicated, and the window values match scenario 2.
4. sort_valid_i kept high after the first window -> second window stays in WAIT until sort_valid_i goes low then high again. start_o pulses exactly once per window.
5. RST=0 while in WAIT during frame 1, then a full new frame -> first start_o comes only after new-frame pixel 11 with window 1,2,3,5,6,7,9,10,11. No start from old data.
6. Two back-to-back frames -> frame_done_o pulses once, the cycle after pixel 16 of each frame. Frame 2 windows are identical to frame 1.

Source files
------------

// File: rtl/median_window_gen.sv
`default_nettype none
// ============================================================================
// Module   : median_window_gen
// Purpose  : Raster-stream 3x3 window generator feeding bubble_sort_unit.
//            Two line buffers hold the previous two rows. Each accepted pixel
//            shifts the window left by one column. Every interior window is
//            handed to the sorter with a one-cycle start pulse, and the input
//            stream is stalled until the sorter reports completion.
// Revision : 1.0 - initial release
// ============================================================================
module median_window_gen #(
  parameter int BITWIDTH   = 8,
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int COL_W      = 10,
  parameter int ROW_W      = 9
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                pix_valid_i,
  input  logic [BITWIDTH-1:0] pix_data_i,
  output logic                pix_ready_o,
  output logic [BITWIDTH-1:0] win0_o,
  output logic [BITWIDTH-1:0] win1_o,
  output logic [BITWIDTH-1:0] win2_o,
  output logic [BITWIDTH-1:0] win3_o,
  output logic [BITWIDTH-1:0] win4_o,
  output logic [BITWIDTH-1:0] win5_o,
  output logic [BITWIDTH-1:0] win6_o,
  output logic [BITWIDTH-1:0] win7_o,
  output logic [BITWIDTH-1:0] win8_o,
  output logic                start_o,
  input  logic                sort_valid_i,
  output logic [ROW_W-1:0]    center_row_o,
  output logic [COL_W-1:0]    center_col_o,
  output logic                frame_done_o
);

  // FSM encoding
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;

  localparam logic [COL_W-1:0] C_COL_LAST = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] C_ROW_LAST = ROW_W'(IMG_HEIGHT - 1);
  localparam logic [COL_W-1:0] C_COL_MIN  = COL_W'(2);
  localparam logic [ROW_W-1:0] C_ROW_MIN  = ROW_W'(2);

  logic [1:0]          r_state;
  logic [COL_W-1:0]    r_col;
  logic [ROW_W-1:0]    r_row;
  logic                r_sv_q;
  logic                r_frame_done;
  logic [ROW_W-1:0]    r_center_row;
  logic [COL_W-1:0]    r_center_col;
  logic [BITWIDTH-1:0] r_win [9];

  // lb0 holds the previous row, lb1 the row before that
  logic [BITWIDTH-1:0] r_lb0 [IMG_WIDTH];
  logic [BITWIDTH-1:0] r_lb1 [IMG_WIDTH];

  logic                w_accept;
  logic                w_win_done;
  logic                w_col_last;
  logic                w_row_last;
  logic                w_sv_rise;
  logic [BITWIDTH-1:0] w_lb0_rd;
  logic [BITWIDTH-1:0] w_lb1_rd;

  // Ready is forced low while reset is held so nothing is accepted in reset
  assign pix_ready_o = RST & (r_state == S_IDLE);
  assign w_accept    = pix_valid_i & pix_ready_o;
  assign w_col_last  = (r_col == C_COL_LAST);
  assign w_row_last  = (r_row == C_ROW_LAST);
  // Window is complete once two full rows and two columns are behind us
  assign w_win_done  = w_accept & (r_row >= C_ROW_MIN) & (r_col >= C_COL_MIN);
  // Only a fresh edge counts, so a level left high by a prior sort is ignored
  assign w_sv_rise   = sort_valid_i & ~r_sv_q;

  assign w_lb0_rd = r_lb0[r_col];
  assign w_lb1_rd = r_lb1[r_col];

  // Line buffers: push the current column down one row on every accept
  always_ff @(posedge CLK) begin
    if (w_accept) begin
      r_lb1[r_col] <= w_lb0_rd;
      r_lb0[r_col] <= pix_data_i;
    end
  end

  // Window register: shift left, load new right column (lb1, lb0, pixel)
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < 9; i++) begin
        r_win[i] <= '0;
      end
    end else if (w_accept) begin
      r_win[0] <= r_win[1];
      r_win[1] <= r_win[2];
      r_win[2] <= w_lb1_rd;
      r_win[3] <= r_win[4];
      r_win[4] <= r_win[5];
      r_win[5] <= w_lb0_rd;
      r_win[6] <= r_win[7];
      r_win[7] <= r_win[8];
      r_win[8] <= pix_data_i;
    end
  end

  // Raster position counters with row and frame wrap
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_col <= '0;
      r_row <= '0;
    end else if (w_accept) begin
      if (w_col_last) begin
        r_col <= '0;
        r_row <= w_row_last ? '0 : r_row + ROW_W'(1);
      end else begin
        r_col <= r_col + COL_W'(1);
      end
    end
  end

  // Frame-done pulse in the cycle after the last pixel of a frame
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_accept & w_col_last & w_row_last;
    end
  end

  // Window centre captured together with the completing pixel
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_center_row <= '0;
      r_center_col <= '0;
    end else if (w_win_done) begin
      r_center_row <= r_row - ROW_W'(1);
      r_center_col <= r_col - COL_W'(1);
    end
  end

  // Registered copy of sort_valid_i for edge detection
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_sv_q <= 1'b0;
    end else begin
      r_sv_q <= sort_valid_i;
    end
  end

  // Handshake FSM: IDLE accepts pixels, START pulses, WAIT holds for the sorter
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (w_win_done) r_state <= S_START;
        S_START: r_state <= S_WAIT;
        S_WAIT:  if (w_sv_rise) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign start_o      = (r_state == S_START);
  assign frame_done_o = r_frame_done;
  assign center_row_o = r_center_row;
  assign center_col_o = r_center_col;

  assign win0_o = r_win[0];
  assign win1_o = r_win[1];
  assign win2_o = r_win[2];
  assign win3_o = r_win[3];
  assign win4_o = r_win[4];
  assign win5_o = r_win[5];
  assign win6_o = r_win[6];
  assign win7_o = r_win[7];
  assign win8_o = r_win[8];

endmodule
`default_nettype wire

// File: tb/tb_median_window_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_median_window_gen
// Purpose  : Self-checking bench for median_window_gen on a 4x4 image with a
//            simple sort-unit model and a frame-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_median_window_gen;

  localparam int BW = 8;
  localparam int W  = 4;
  localparam int H  = 4;
  localparam int CW = 2;
  localparam int RW = 2;

  logic          CLK;
  logic          RST;
  logic          pix_valid_i;
  logic [BW-1:0] pix_data_i;
  logic          pix_ready_o;
  logic [BW-1:0] win0_o, win1_o, win2_o, win3_o, win4_o, win5_o, win6_o, win7_o, win8_o;
  logic          start_o;
  logic          sort_valid_i;
  logic [RW-1:0] center_row_o;
  logic [CW-1:0] center_col_o;
  logic          frame_done_o;

  median_window_gen #(
    .BITWIDTH(BW), .IMG_WIDTH(W), .IMG_HEIGHT(H), .COL_W(CW), .ROW_W(RW)
  ) dut (
    .CLK(CLK), .RST(RST),
    .pix_valid_i(pix_valid_i), .pix_data_i(pix_data_i), .pix_ready_o(pix_ready_o),
    .win0_o(win0_o), .win1_o(win1_o), .win2_o(win2_o),
    .win3_o(win3_o), .win4_o(win4_o), .win5_o(win5_o),
    .win6_o(win6_o), .win7_o(win7_o), .win8_o(win8_o),
    .start_o(start_o), .sort_valid_i(sort_valid_i),
    .center_row_o(center_row_o), .center_col_o(center_col_o),
    .frame_done_o(frame_done_o)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model (frame image + handshake rules) -------
  logic [BW-1:0] img [H][W];
  int            m_k      = 0;   // pixel index within the frame
  int            m_phase  = 0;   // 0 accepting, 1 start cycle, 2 waiting for sorter
  logic          m_ready  = 1'b0;
  logic          m_sv_prev = 1'b0;
  logic          exp_start = 1'b0;
  logic          exp_fd    = 1'b0;
  logic [BW-1:0] exp_win [9];
  int            exp_cr = 0;
  int            exp_cc = 0;

  // DUT-observed log of started windows
  logic [BW-1:0] logw [32][9];
  int            logr [32];
  int            logc [32];
  int            nlog   = 0;
  int            fd_cnt = 0;

  // Model advance on each clock edge using pre-edge input values
  always @(posedge CLK) begin
    logic sv_rise;
    int r, c;
    if (RST) begin
      sv_rise   = sort_valid_i && !m_sv_prev;
      m_sv_prev = sort_valid_i;
      exp_start = 1'b0;
      exp_fd    = 1'b0;
      if (m_phase == 1) m_phase = 2;
      else if (m_phase == 2 && sv_rise) m_phase = 0;
      if (pix_valid_i && m_ready) begin
        r = m_k / W;
        c = m_k % W;
        img[r][c] = pix_data_i;
        m_k++;
        if (m_k == W * H) begin
          m_k    = 0;
          exp_fd = 1'b1;
        end
        if (r >= 2 && c >= 2) begin
          for (int i = 0; i < 9; i++) exp_win[i] = img[r - 2 + i / 3][c - 2 + i % 3];
          exp_cr    = r - 1;
          exp_cc    = c - 1;
          exp_start = 1'b1;
          m_phase   = 1;
        end
      end
      m_ready = (m_phase == 0);
    end
  end

  // Compare process, sampling mid-cycle
  always @(negedge CLK) begin
    logic [BW-1:0] dw [9];
    dw = '{win0_o, win1_o, win2_o, win3_o, win4_o, win5_o, win6_o, win7_o, win8_o};
    if (!RST) begin
      chk("rst_ready", {31'd0, pix_ready_o}, 0);
      chk("rst_start", {31'd0, start_o}, 0);
      chk("rst_fdone", {31'd0, frame_done_o}, 0);
      chk("rst_center", {28'd0, center_row_o, center_col_o}, 0);
      for (int i = 0; i < 9; i++) chk("rst_win", {24'd0, dw[i]}, 0);
      m_k = 0; m_phase = 0; m_ready = 1'b1; m_sv_prev = 1'b0;
      exp_start = 1'b0; exp_fd = 1'b0;
    end else begin
      chk("ready", {31'd0, pix_ready_o}, {31'd0, m_ready});
      chk("start", {31'd0, start_o}, {31'd0, exp_start});
      chk("frame_done", {31'd0, frame_done_o}, {31'd0, exp_fd});
      if (m_phase != 0) begin
        for (int i = 0; i < 9; i++) chk("win", {24'd0, dw[i]}, {24'd0, exp_win[i]});
        chk("center_row", {30'd0, center_row_o}, exp_cr);
        chk("center_col", {30'd0, center_col_o}, exp_cc);
      end
      if (start_o && nlog < 32) begin
        for (int i = 0; i < 9; i++) logw[nlog][i] = dw[i];
        logr[nlog] = int'(center_row_o);
        logc[nlog] = int'(center_col_o);
        nlog++;
      end
      if (frame_done_o) fd_cnt++;
    end
  end

  // ---------------- sort unit model ----------------------------------------
  // mode 0: pulse 3 cycles after start, 1: random latency pulse, 2: sticky level
  int sort_mode = 0;
  initial begin
    int lat;
    sort_valid_i = 1'b0;
    forever begin
      @(posedge CLK);
      if (RST && start_o) begin
        lat = (sort_mode == 1) ? int'($urandom_range(1, 5)) : 3;
        repeat (lat - 1) @(posedge CLK);
        #2;
        if (sort_mode == 2 && sort_valid_i) begin
          repeat (6) @(posedge CLK);
          #2 sort_valid_i = 1'b0;
          @(posedge CLK);
          #2 sort_valid_i = 1'b1;
        end else begin
          sort_valid_i = 1'b1;
          if (sort_mode != 2) begin
            @(posedge CLK);
            #2 sort_valid_i = 1'b0;
          end
        end
      end
    end
  end

  // ---------------- stimulus helpers (called at posedge + 2) ---------------
  task automatic send_pixel(input logic [BW-1:0] d, input int gap);
    int  cnt;
    logic acc;
    repeat (gap) begin @(posedge CLK); #2; end
    pix_valid_i = 1'b1;
    pix_data_i  = d;
    cnt = 0;
    acc = 1'b0;
    while (!acc && cnt < 200) begin
      @(posedge CLK);
      acc = pix_ready_o;
      cnt++;
    end
    if (!acc) begin
      tests++; fails++;
      $display("FAIL accept_timeout: got no ready expected ready within 200 cycles");
    end
    #2 pix_valid_i = 1'b0;
  endtask

  task automatic send_frame(input bit rnd, input int maxgap);
    for (int idx = 0; idx < W * H; idx++)
      send_pixel(rnd ? BW'($urandom) : BW'(idx + 1), int'($urandom_range(0, maxgap)));
  endtask

  task automatic wait_idle();
    int cnt = 0;
    while (!pix_ready_o && cnt < 200) begin @(posedge CLK); cnt++; end
    if (!pix_ready_o) begin
      tests++; fails++;
      $display("FAIL idle_timeout: got ready=0 expected ready=1");
    end
    #2;
  endtask

  task automatic do_reset(input int cycles);
    RST = 1'b0;
    repeat (cycles) begin @(posedge CLK); #2; end
    RST = 1'b1;
  endtask

  // Check logged windows of the counting pattern (pixel = r*4+c+1)
  task automatic chk_pattern_log(input string nm, input int first, input int n);
    int cr [4] = '{1, 1, 2, 2};
    int cc [4] = '{1, 2, 1, 2};
    for (int j = 0; j < n; j++) begin
      chk({nm, "_crow"}, logr[first + j], cr[j % 4]);
      chk({nm, "_ccol"}, logc[first + j], cc[j % 4]);
      for (int i = 0; i < 9; i++)
        chk({nm, "_win"}, {24'd0, logw[first + j][i]},
            (cr[j % 4] - 1 + i / 3) * W + (cc[j % 4] - 1 + i % 3) + 1);
    end
  endtask

  initial begin
    int lit [9] = '{1, 2, 3, 5, 6, 7, 9, 10, 11};
    RST = 1'b0; pix_valid_i = 1'b0; pix_data_i = '0;
    repeat (3) @(posedge CLK);
    #2 RST = 1'b1;

    // 1: reset in the middle of idle streaming
    for (int i = 0; i < 3; i++) send_pixel(BW'(100 + i), 0);
    do_reset(2);
    @(posedge CLK); #2;

    // 2: counting pattern with gaps
    nlog = 0; fd_cnt = 0; sort_mode = 0;
    send_frame(1'b0, 2);
    wait_idle();
    chk("s2_nwin", nlog, 4);
    chk("s2_fdone", fd_cnt, 1);
    for (int i = 0; i < 9; i++) chk("s2_lit_win", {24'd0, logw[0][i]}, lit[i]);
    chk("s2_lit_crow", logr[0], 1);
    chk("s2_lit_ccol", logc[0], 1);
    chk_pattern_log("s2", 0, 4);

    // 3: valid held high continuously
    nlog = 0;
    send_frame(1'b0, 0);
    wait_idle();
    chk("s3_nwin", nlog, 4);
    chk_pattern_log("s3", 0, 4);

    // 4: sorter leaves valid high between windows
    nlog = 0; sort_mode = 2;
    send_frame(1'b0, 1);
    wait_idle();
    chk("s4_nwin", nlog, 4);
    chk_pattern_log("s4", 0, 4);
    sort_mode = 0;
    sort_valid_i = 1'b0;
    @(posedge CLK); #2;

    // 5: reset while waiting for the sorter, then a clean frame
    for (int i = 0; i < 11; i++) send_pixel(BW'(50 + i), 0);
    @(posedge CLK); #2;
    do_reset(2);
    repeat (4) begin @(posedge CLK); #2; end
    nlog = 0;
    send_frame(1'b0, 1);
    wait_idle();
    chk("s5_nwin", nlog, 4);
    for (int i = 0; i < 9; i++) chk("s5_lit_win", {24'd0, logw[0][i]}, lit[i]);
    chk_pattern_log("s5", 0, 4);

    // 6: two back-to-back frames
    nlog = 0; fd_cnt = 0;
    send_frame(1'b0, 0);
    send_frame(1'b0, 0);
    wait_idle();
    chk("s6_nwin", nlog, 8);
    chk("s6_fdone", fd_cnt, 2);
    chk_pattern_log("s6", 0, 8);

    // 7: random data, gaps and sort latency against the model
    fd_cnt = 0; sort_mode = 1;
    for (int f = 0; f < 4; f++) send_frame(1'b1, 2);
    wait_idle();
    chk("s7_fdone", fd_cnt, 4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish expected finish before 1ms");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
